pergate_round_ctrl: RTL and testbench

Sequencer and collector on the initiating side of the per-gate compute interface. Drives `en`/`restart`/`precomp` to a bank of `NGATES` per-gate compute instances sharing one control bus, waits for the whole bank to finish, and sums each gate's three-point contribution modulo the field prime. Emits one sumcheck round message {H(0), H(1), H(2)} per non-precompute round and holds it until the round-challenge logic acknowledges it. Sits between the per-gate bank and the prover layer state machine.

---
 rtl/pergate_round_ctrl_pkg.sv | 23 ++
 rtl/pergate_round_ctrl_if.sv | 36 +++
 rtl/field_modadd_seq.sv | 18 +
 rtl/pergate_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pergate_round_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pergate_round_ctrl_pkg.sv
// Shared types and constants for the per-gate round controller.
// Field: F_NBITS-bit prime field, p = 2^61 - 1.
package pergate_round_ctrl_pkg;

  localparam int unsigned F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_PRIME = {F_NBITS{1'b1}};

  // Cycles after a launch during which bank ready is not trusted.
  localparam int unsigned GuardCycles = 3;
  // Evaluation points per gate: f(0), f(1), f(2).
  localparam int unsigned NumLanes = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StGuard,
    StWait,
    StAccum,
    StPresent,
    StFin
  } state_e;

endpackage

// File: rtl/pergate_round_ctrl_if.sv
// Control/data bus between the round controller (master), its launcher
// (start/done), the per-gate bank and the round-challenge consumer.
interface pergate_round_ctrl_if
  import pergate_round_ctrl_pkg::*;
#(
  parameter int unsigned NGATES  = 4,
  parameter int unsigned NROUNDS = 6
) ();

  localparam int unsigned KW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;

  logic                                          start;
  logic                                          busy;
  logic                                          pg_en;
  logic                                          pg_restart;
  logic                                          pg_precomp;
  logic [NGATES-1:0]                             pg_ready;
  logic [NGATES-1:0][NumLanes-1:0][F_NBITS-1:0]  pg_out;
  logic                                          rnd_valid;
  logic                                          rnd_ack;
  logic [KW-1:0]                                 rnd_idx;
  logic [NumLanes-1:0][F_NBITS-1:0]              rnd_h;
  logic                                          done;
  logic                                          wdog_err;

  modport master (
    input  start, pg_ready, pg_out, rnd_ack,
    output busy, pg_en, pg_restart, pg_precomp, rnd_valid, rnd_idx, rnd_h, done, wdog_err
  );

  modport slave (
    output start, pg_ready, pg_out, rnd_ack,
    input  busy, pg_en, pg_restart, pg_precomp, rnd_valid, rnd_idx, rnd_h, done, wdog_err
  );

endinterface

// File: rtl/field_modadd_seq.sv
// Combinational modular adder: (a + b) mod p for a, b < p.
module field_modadd_seq
  import pergate_round_ctrl_pkg::*;
(
  input  logic [F_NBITS-1:0] i_a,
  input  logic [F_NBITS-1:0] i_b,
  output logic [F_NBITS-1:0] o_sum
);

  logic [F_NBITS:0] w_sum;
  logic             w_ge;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_ge  = (w_sum >= {1'b0, F_PRIME});
  // The reduced result is < p < 2^F_NBITS, so F_NBITS-bit wraparound is exact.
  assign o_sum = w_ge ? (i_a + i_b - F_PRIME) : (i_a + i_b);

endmodule

// File: rtl/pergate_round_ctrl.sv
// Sequencer/collector for a bank of per-gate compute instances: launches
// NROUNDS rounds per level (first NPRE as precompute), sums the bank's
// three-point outputs mod p and presents one round message per round.
// Optional watchdog on the bank wait: define PERGATE_ROUND_CTRL_WDOG_EN.
module pergate_round_ctrl
  import pergate_round_ctrl_pkg::*;
#(
  parameter int unsigned NGATES      = 4,
  parameter int unsigned NROUNDS     = 6,
  parameter int unsigned NPRE        = 2,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rstb,
  pergate_round_ctrl_if.master   io_bus
);

  localparam int unsigned KW     = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
  localparam int unsigned GW     = (NGATES > 1) ? $clog2(NGATES) : 1;
  localparam int unsigned GuardW = $clog2(GuardCycles);

  state_e                            r_state;
  logic [KW-1:0]                     r_k;
  logic [GW-1:0]                     r_g;
  logic [GuardW-1:0]                 r_guard;
  logic [NumLanes-1:0][F_NBITS-1:0]  r_acc;
  logic                              r_busy;
  logic                              r_pg_en;
  logic                              r_pg_restart;
  logic                              r_pg_precomp;
  logic                              r_rnd_valid;
  logic                              r_done;
  logic                              r_wdog_err;

  logic [NumLanes-1:0][F_NBITS-1:0]  w_gate_out;
  logic [NumLanes-1:0][F_NBITS-1:0]  w_sum;
  logic                              w_all_ready;

  assign w_gate_out  = io_bus.pg_out[r_g];
  assign w_all_ready = &io_bus.pg_ready;

  for (genvar j = 0; j < NumLanes; j++) begin : g_lane
    field_modadd_seq u_add (
      .i_a   (r_acc[j]),
      .i_b   (w_gate_out[j]),
      .o_sum (w_sum[j])
    );
  end

`ifdef PERGATE_ROUND_CTRL_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
`endif

  // Level sequencer; all bus outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rstb) begin
      r_state      <= StIdle;
      r_k          <= '0;
      r_g          <= '0;
      r_guard      <= '0;
      r_acc        <= '0;
      r_busy       <= 1'b0;
      r_pg_en      <= 1'b0;
      r_pg_restart <= 1'b0;
      r_pg_precomp <= 1'b0;
      r_rnd_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_wdog_err   <= 1'b0;
`ifdef PERGATE_ROUND_CTRL_WDOG_EN
      r_wdog       <= '0;
`endif
    end else begin
      // Launch qualifiers and done are single-cycle pulses.
      r_pg_en      <= 1'b0;
      r_pg_restart <= 1'b0;
      r_pg_precomp <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_k          <= '0;
            r_busy       <= 1'b1;
            r_pg_en      <= 1'b1;
            r_pg_restart <= 1'b1;
            r_pg_precomp <= (NPRE > 0);
            r_state      <= StLaunch;
          end
        end
        StLaunch: begin
          r_guard <= '0;
          r_state <= StGuard;
        end
        StGuard: begin
          if (r_guard == GuardW'(GuardCycles - 1)) begin
            r_state <= StWait;
`ifdef PERGATE_ROUND_CTRL_WDOG_EN
            r_wdog  <= '0;
`endif
          end else begin
            r_guard <= r_guard + GuardW'(1);
          end
        end
        StWait: begin
          if (w_all_ready) begin
            if (int'(r_k) < int'(NPRE)) begin
              r_k          <= r_k + KW'(1);
              r_pg_en      <= 1'b1;
              r_pg_precomp <= (int'(r_k) + 1 < int'(NPRE));
              r_state      <= StLaunch;
            end else begin
              r_acc   <= '0;
              r_g     <= '0;
              r_state <= StAccum;
            end
          end
`ifdef PERGATE_ROUND_CTRL_WDOG_EN
          else if (r_wdog == WW'(WDOG_CYCLES - 1)) begin
            r_wdog_err <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= StIdle;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
`endif
        end
        StAccum: begin
          r_acc <= w_sum;
          if (r_g == GW'(NGATES - 1)) begin
            r_rnd_valid <= 1'b1;
            r_state     <= StPresent;
          end else begin
            r_g <= r_g + GW'(1);
          end
        end
        StPresent: begin
          if (io_bus.rnd_ack) begin
            r_rnd_valid <= 1'b0;
            if (int'(r_k) == int'(NROUNDS) - 1) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_k          <= r_k + KW'(1);
              r_pg_en      <= 1'b1;
              r_pg_precomp <= (int'(r_k) + 1 < int'(NPRE));
              r_state      <= StLaunch;
            end
          end
        end
        StFin: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.pg_en      = r_pg_en;
  assign io_bus.pg_restart = r_pg_restart;
  assign io_bus.pg_precomp = r_pg_precomp;
  assign io_bus.rnd_valid  = r_rnd_valid;
  assign io_bus.rnd_idx    = r_k;
  assign io_bus.rnd_h      = r_acc;
  assign io_bus.done       = r_done;
  assign io_bus.wdog_err   = r_wdog_err;

endmodule

// File: tb/tb_pergate_round_ctrl.sv
// Directed + randomized bench for pergate_round_ctrl (default build).
module tb_pergate_round_ctrl;
  import pergate_round_ctrl_pkg::*;

  localparam int unsigned NGATES  = 4;
  localparam int unsigned NROUNDS = 6;
  localparam int unsigned NPRE    = 2;

  logic clk = 1'b0;
  logic rstb;
  int   n_checks = 0;
  int   n_errs   = 0;
  logic [NumLanes-1:0][F_NBITS-1:0] last_h;

  always #5 clk = ~clk;

  pergate_round_ctrl_if #(.NGATES(NGATES), .NROUNDS(NROUNDS)) bus ();

  pergate_round_ctrl #(
    .NGATES      (NGATES),
    .NROUNDS     (NROUNDS),
    .NPRE        (NPRE),
    .WDOG_CYCLES (1024)
  ) u_dut (
    .i_clk  (clk),
    .i_rstb (rstb),
    .io_bus (bus.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide sum of all gates for lane j, reduced once.
  function automatic logic [63:0] model_h(input int j);
    logic [63:0] s;
    s = '0;
    for (int g = 0; g < NGATES; g++) s += 64'(bus.pg_out[g][j]);
    return s % 64'(F_PRIME);
  endfunction

  function automatic logic [F_NBITS-1:0] rand_fe();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v = v & {3'b000, {F_NBITS{1'b1}}};
    if (v[F_NBITS-1:0] == F_PRIME) v = '0;
    return v[F_NBITS-1:0];
  endfunction

  task automatic randomize_bank();
    for (int g = 0; g < NGATES; g++)
      for (int j = 0; j < NumLanes; j++) bus.pg_out[g][j] = rand_fe();
  endtask

  // One full level with ready always high; checks launches, messages, timing.
  task automatic run_level(input int ack_delay, input bit rnd_mode, input bit poke_start);
    int n_en = 0, n_done = 0, n_msg = 0, stray = 0, unstable = 0;
    int restart_mask = 0, precomp_mask = 0;
    int t_en = 0, t_ack = -1, cyc;
    bit timing_ok = 1'b1;
    logic [NumLanes-1:0][F_NBITS-1:0] held;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 3000 && n_done == 0) begin
      if (bus.pg_en) begin
        if (n_en == 0 && cyc != 1) timing_ok = 1'b0;
        if (n_en > 0 && t_ack < 0 && cyc - t_en != 5) timing_ok = 1'b0;
        if (t_ack >= 0 && cyc != t_ack + 1) timing_ok = 1'b0;
        t_ack = -1;
        if (bus.pg_restart) restart_mask |= (1 << n_en);
        if (bus.pg_precomp) precomp_mask |= (1 << n_en);
        t_en = cyc;
        n_en++;
        if (rnd_mode) randomize_bank();
      end else if (bus.pg_restart || bus.pg_precomp) begin
        stray++;
      end
      if (bus.done) n_done++;
      if (bus.rnd_valid) begin
        n_msg++;
        if (cyc - t_en != 5 + NGATES) timing_ok = 1'b0;
        check("rnd_idx", 64'(bus.rnd_idx), 64'(NPRE + n_msg - 1));
        for (int j = 0; j < NumLanes; j++) check("rnd_h", 64'(bus.rnd_h[j]), model_h(j));
        held = bus.rnd_h;
        for (int h = 0; h < ack_delay; h++) begin
          if (poke_start) bus.start = 1'b1;
          @(negedge clk);
          cyc++;
          bus.start = 1'b0;
          if (bus.rnd_valid !== 1'b1 || bus.rnd_h !== held || bus.pg_en !== 1'b0) unstable++;
        end
        bus.rnd_ack = 1'b1;
        t_ack = cyc;
        @(negedge clk);
        cyc++;
        bus.rnd_ack = 1'b0;
        last_h = held;
        continue;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (5) begin
      if (bus.done) n_done++;
      if (bus.pg_en) n_en++;
      @(negedge clk);
    end
    check("pg_en_count", 64'(n_en), 64'(NROUNDS));
    check("restart_mask", 64'(restart_mask), 64'd1);
    check("precomp_mask", 64'(precomp_mask), 64'((1 << NPRE) - 1));
    check("msg_count", 64'(n_msg), 64'(NROUNDS - NPRE));
    check("done_count", 64'(n_done), 64'd1);
    check("qual_without_en", 64'(stray), 64'd0);
    check("hold_stable", 64'(unstable), 64'd0);
    check("timing", 64'(timing_ok), 64'd1);
    check("busy_after", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int cnt;
    int bad;
    rstb         = 1'b1;
    bus.start    = 1'b0;
    bus.rnd_ack  = 1'b0;
    bus.pg_ready = '1;
    bus.pg_out   = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b0;

    // Reset state
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_pg_en", 64'(bus.pg_en), 64'd0);
    check("rst_valid", 64'(bus.rnd_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_idx", 64'(bus.rnd_idx), 64'd0);
    check("rst_h", 64'(bus.rnd_h == '0), 64'd1);
    check("rst_wdog", 64'(bus.wdog_err), 64'd0);

    // f(j) = j+1 in every gate, ack in first valid cycle
    for (int g = 0; g < NGATES; g++)
      for (int j = 0; j < NumLanes; j++) bus.pg_out[g][j] = F_NBITS'(j + 1);
    run_level(0, 1'b0, 1'b0);
    check("dir_h0", 64'(last_h[0]), 64'd4);
    check("dir_h1", 64'(last_h[1]), 64'd8);
    check("dir_h2", 64'(last_h[2]), 64'd12);

    // Wraparound; long ack hold with stray start pulses
    bus.pg_out = '0;
    bus.pg_out[0][0] = F_PRIME - 1;
    bus.pg_out[1][0] = F_NBITS'(2);
    for (int g = 0; g < NGATES; g++) begin
      bus.pg_out[g][1] = F_PRIME - 1;
      bus.pg_out[g][2] = rand_fe();
    end
    run_level(10, 1'b0, 1'b1);
    check("wrap_h0", 64'(last_h[0]), 64'd1);
    check("wrap_h1", 64'(last_h[1]), 64'(F_PRIME - 4));

    // Randomized bank values and ack delays
    for (int l = 0; l < 3; l++) run_level(int'($urandom_range(0, 3)), 1'b1, 1'b0);

    // Reset during ACCUM
    cnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200 && cnt < NPRE + 1; c++) begin
      if (bus.pg_en) cnt++;
      if (cnt < NPRE + 1) @(negedge clk);
    end
    check("find_launch", 64'(cnt), 64'(NPRE + 1));
    repeat (6) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_pg_en", 64'(bus.pg_en), 64'd0);
    check("mid_valid", 64'(bus.rnd_valid), 64'd0);
    check("mid_h", 64'(bus.rnd_h == '0), 64'd1);
    check("mid_idx", 64'(bus.rnd_idx), 64'd0);
    bad = 0;
    repeat (20) begin
      if (bus.done || bus.rnd_valid || bus.pg_en || bus.busy) bad++;
      @(negedge clk);
    end
    check("mid_quiet", 64'(bad), 64'd0);
    run_level(1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
